// File: rtl/id_stage_if.sv
// Bundle carrying the decode stage's bus traffic: fetch handshake, register-file
// read port, ID/EX pipeline outputs, writeback retire and the flush request.
// The stage itself takes the slave view; the surrounding pipeline takes master.
interface id_stage_if #(
    parameter int XLEN = 16
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic [2:0]      rf_src1;
    logic [2:0]      rf_src2;
    logic [XLEN-1:0] rf_src1_val;
    logic [XLEN-1:0] rf_src2_val;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_op;
    logic            out_we;
    logic [2:0]      out_tgt;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic            wb_valid;
    logic [2:0]      wb_tgt;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, rf_src1_val, rf_src2_val,
               out_ready, wb_valid, wb_tgt, wb_data,
        output in_ready, rf_src1, rf_src2, out_valid, out_op, out_we, out_tgt,
               out_a, out_b, out_imm, out_pc
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, rf_src1_val, rf_src2_val,
               out_ready, wb_valid, wb_tgt, wb_data,
        input  in_ready, rf_src1, rf_src2, out_valid, out_op, out_we, out_tgt,
               out_a, out_b, out_imm, out_pc
    );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage for the 16-bit RiSC pipeline. Decodes the fetched
// word, addresses the register file combinationally, tracks pending register
// writes to stall RAW/WAW hazards, and loads the ID/EX register on issue.
// Optional build macro ID_WB_BYPASS_EN: writeback clears the hazard in the
// same cycle and forwards wb_data onto matching source operands.
module id_stage #(
    parameter int XLEN = 16,
    parameter int NREG = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    id_stage_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_NAND = 3'd2,
        OP_LUI  = 3'd3,
        OP_SW   = 3'd4,
        OP_LW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_JALR = 3'd7
    } opcode_e;

    opcode_e         op;
    logic [2:0]      src1, src2, tgt;
    logic            has_tgt, we;
    logic [XLEN-1:0] imm;
    logic [NREG-1:0] pend_vis;
    logic            hazard, slot_free, issue;
    logic [XLEN-1:0] opnd_a, opnd_b;

    logic            out_valid_d, out_valid_q;
    logic [2:0]      out_op_d, out_op_q;
    logic            out_we_d, out_we_q;
    logic [2:0]      out_tgt_d, out_tgt_q;
    logic [XLEN-1:0] out_a_d, out_a_q;
    logic [XLEN-1:0] out_b_d, out_b_q;
    logic [XLEN-1:0] out_imm_d, out_imm_q;
    logic [XLEN-1:0] out_pc_d, out_pc_q;
    logic [NREG-1:0] pending_d, pending_q;

    // Field decode: pick source/target registers and immediate per opcode.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op      = opcode_e'(bus.in_instr[15:13]);
        src1    = 3'd0;
        src2    = 3'd0;
        tgt     = 3'd0;
        has_tgt = 1'b0;
        imm     = '0;
        unique case (op)
            OP_ADD, OP_NAND: begin
                src1    = bus.in_instr[9:7];
                src2    = bus.in_instr[2:0];
                tgt     = bus.in_instr[12:10];
                has_tgt = 1'b1;
            end
            OP_ADDI, OP_LW, OP_JALR: begin
                src1    = bus.in_instr[9:7];
                tgt     = bus.in_instr[12:10];
                has_tgt = 1'b1;
                imm     = {{(XLEN-7){bus.in_instr[6]}}, bus.in_instr[6:0]};
            end
            OP_LUI: begin
                tgt     = bus.in_instr[12:10];
                has_tgt = 1'b1;
                imm     = {bus.in_instr[9:0], 6'b0};
            end
            OP_SW: begin
                src1 = bus.in_instr[9:7];
                src2 = bus.in_instr[12:10];
                imm  = {{(XLEN-7){bus.in_instr[6]}}, bus.in_instr[6:0]};
            end
            OP_BEQ: begin
                src1 = bus.in_instr[12:10];
                src2 = bus.in_instr[9:7];
                imm  = {{(XLEN-7){bus.in_instr[6]}}, bus.in_instr[6:0]};
            end
            default: ;
        endcase
        we = has_tgt && (tgt != 3'd0);
    end

    // Hazard check and operand selection; unused sources sit at r0, never pending.
    always_comb begin
        pend_vis = pending_q;
        opnd_a   = bus.rf_src1_val;
        opnd_b   = bus.rf_src2_val;
`ifdef ID_WB_BYPASS_EN
        if (bus.wb_valid) pend_vis[bus.wb_tgt] = 1'b0;
        if (bus.wb_valid && bus.wb_tgt != 3'd0 && bus.wb_tgt == src1) opnd_a = bus.wb_data;
        if (bus.wb_valid && bus.wb_tgt != 3'd0 && bus.wb_tgt == src2) opnd_b = bus.wb_data;
`endif
        hazard    = bus.in_valid && (pend_vis[src1] || pend_vis[src2] || (we && pend_vis[tgt]));
        slot_free = !out_valid_q || bus.out_ready;
        issue     = bus.in_valid && slot_free && !hazard && !bus.flush;
    end

`ifndef ID_WB_BYPASS_EN
    logic unused_wb_data;
    assign unused_wb_data = ^bus.wb_data;
`endif

    // ID/EX register next state: flush kills, issue loads, consume drains, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_we_d    = out_we_q;
        out_tgt_d   = out_tgt_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_imm_d   = out_imm_q;
        out_pc_d    = out_pc_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d = 1'b1;
            out_op_d    = bus.in_instr[15:13];
            out_we_d    = we;
            out_tgt_d   = tgt;
            out_a_d     = opnd_a;
            out_b_d     = opnd_b;
            out_imm_d   = imm;
            out_pc_d    = bus.in_pc;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Scoreboard: clears (writeback, flushed producer) first, then issue set wins.
    always_comb begin
        pending_d = pending_q;
        if (bus.wb_valid) pending_d[bus.wb_tgt] = 1'b0;
        if (bus.flush && out_valid_q && out_we_q) pending_d[out_tgt_q] = 1'b0;
        if (issue && we) pending_d[tgt] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // State registers with asynchronous clear of the pipeline slot and scoreboard.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_op_q    <= 3'd0;
            out_we_q    <= 1'b0;
            out_tgt_q   <= 3'd0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
            pending_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_we_q    <= out_we_d;
            out_tgt_q   <= out_tgt_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_imm_q   <= out_imm_d;
            out_pc_q    <= out_pc_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.in_ready  = slot_free && !hazard && !bus.flush;
    assign bus.rf_src1   = src1;
    assign bus.rf_src2   = src2;
    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_op_q;
    assign bus.out_we    = out_we_q;
    assign bus.out_tgt   = out_tgt_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_pc    = out_pc_q;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: handshake, scoreboard stalls, pipeline stall,
// flush, writeback races and reset. Register file modelled as r[n] = 0x1100*n.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_stage_if bus ();
    id_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [15:0] rf_val(input logic [2:0] a);
        return 16'h1100 * {13'b0, a};
    endfunction
    assign bus.rf_src1_val = rf_val(bus.rf_src1);
    assign bus.rf_src2_val = rf_val(bus.rf_src2);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [2:0] op, input logic we,
                             input logic [2:0] tgt, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] imm, input logic [15:0] pc);
        check({tag, ".valid"}, bus.out_valid, 1'b1);
        check({tag, ".op"},    bus.out_op,    op);
        check({tag, ".we"},    bus.out_we,    we);
        check({tag, ".tgt"},   bus.out_tgt,   tgt);
        check({tag, ".a"},     bus.out_a,     a);
        check({tag, ".b"},     bus.out_b,     b);
        check({tag, ".imm"},   bus.out_imm,   imm);
        check({tag, ".pc"},    bus.out_pc,    pc);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.flush = 0; bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0;
        bus.out_ready = 0; bus.wb_valid = 0; bus.wb_tgt = '0; bus.wb_data = '0;
        tick();
        check("rst.out_valid", bus.out_valid, 1'b0);
        check("rst.pending",   dut.pending_q, 8'h00);
        check("rst.out_imm",   bus.out_imm,   16'h0);
        check("rst.out_pc",    bus.out_pc,    16'h0);
        check("rst.in_ready",  bus.in_ready,  1'b1);
        rst_n = 1'b1;

        // 1: ADDI r1,r0,5
        bus.in_valid = 1; bus.in_instr = 16'h2405; bus.in_pc = 16'h0010; bus.out_ready = 1;
        #1 check("t1.in_ready", bus.in_ready, 1'b1);
        tick();
        check_out("t1", 3'd1, 1'b1, 3'd1, 16'h0, 16'h0, 16'h0005, 16'h0010);
        check("t1.pending", dut.pending_q, 8'h02);

        // 2: ADD r2,r1,r1 RAW on r1
        bus.in_instr = 16'h0881; bus.in_pc = 16'h0012;
        #1 check("t2.in_ready_raw", bus.in_ready, 1'b0);
        check("t2.rf_src1", bus.rf_src1, 3'd1);
        check("t2.rf_src2", bus.rf_src2, 3'd1);
        tick();
        check("t2.drained", bus.out_valid, 1'b0);
        check("t2.still_stalled", bus.in_ready, 1'b0);
        bus.wb_valid = 1; bus.wb_tgt = 3'd1; bus.wb_data = 16'h0005;
        #1;
`ifdef ID_WB_BYPASS_EN
        check("t2.in_ready_wb", bus.in_ready, 1'b1);
        tick();
        bus.wb_valid = 0;
        check_out("t2", 3'd0, 1'b1, 3'd2, 16'h0005, 16'h0005, 16'h0, 16'h0012);
`else
        check("t2.in_ready_wb", bus.in_ready, 1'b0);
        tick();
        bus.wb_valid = 0;
        check("t2.pending_cleared", dut.pending_q, 8'h00);
        #1 check("t2.in_ready_after", bus.in_ready, 1'b1);
        tick();
        check_out("t2", 3'd0, 1'b1, 3'd2, 16'h1100, 16'h1100, 16'h0, 16'h0012);
`endif
        check("t2.pending", dut.pending_q, 8'h04);

        // 3: LW r3 then LW r3 (WAW)
        bus.in_instr = 16'hAC02; bus.in_pc = 16'h0014;
        #1 check("t3.in_ready1", bus.in_ready, 1'b1);
        tick();
        check_out("t3a", 3'd5, 1'b1, 3'd3, 16'h0, 16'h0, 16'h0002, 16'h0014);
        check("t3.pending1", dut.pending_q, 8'h0C);
        bus.in_pc = 16'h0016;
        #1 check("t3.in_ready_waw", bus.in_ready, 1'b0);
        tick();
        check("t3.drained", bus.out_valid, 1'b0);
        bus.wb_valid = 1; bus.wb_tgt = 3'd3; bus.wb_data = 16'h3333;
        #1;
`ifdef ID_WB_BYPASS_EN
        check("t3.in_ready_wb", bus.in_ready, 1'b1);
        tick();
        bus.wb_valid = 0;
`else
        check("t3.in_ready_wb", bus.in_ready, 1'b0);
        tick();
        bus.wb_valid = 0;
        check("t3.pending_mid", dut.pending_q, 8'h04);
        #1 check("t3.in_ready_after", bus.in_ready, 1'b1);
        tick();
`endif
        check_out("t3b", 3'd5, 1'b1, 3'd3, 16'h0, 16'h0, 16'h0002, 16'h0016);
        check("t3.pending2", dut.pending_q, 8'h0C);

        // 4: downstream stall for 3 cycles
        bus.out_ready = 0; bus.in_instr = 16'h7A01; bus.in_pc = 16'h0018;
        #1 check("t4.in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("t4.hold", 3'd5, 1'b1, 3'd3, 16'h0, 16'h0, 16'h0002, 16'h0016);
            check("t4.in_ready_hold", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1;
        #1 check("t4.in_ready_release", bus.in_ready, 1'b1);
        tick();
        check_out("t4.lui", 3'd3, 1'b1, 3'd6, 16'h0, 16'h0, 16'h8040, 16'h0018);
        check("t4.pending", dut.pending_q, 8'h4C);

        // 5: flush while ADDI r4 is held
        bus.in_instr = 16'h307F; bus.in_pc = 16'h001A;
        tick();
        check_out("t5.addi", 3'd1, 1'b1, 3'd4, 16'h0, 16'h0, 16'hFFFF, 16'h001A);
        check("t5.pending_set", dut.pending_q, 8'h5C);
        bus.out_ready = 0; bus.flush = 1; bus.in_instr = 16'h3403; bus.in_pc = 16'h001C;
        #1 check("t5.in_ready_flush", bus.in_ready, 1'b0);
        tick();
        bus.flush = 0;
        check("t5.out_valid", bus.out_valid, 1'b0);
        check("t5.pending", dut.pending_q, 8'h4C);

        // 6: writeback to r5 in the same cycle ADDI r5 issues
        bus.out_ready = 1; bus.wb_valid = 1; bus.wb_tgt = 3'd5; bus.wb_data = 16'h7777;
        #1 check("t6.in_ready", bus.in_ready, 1'b1);
        tick();
        bus.wb_valid = 0;
        check_out("t6.addi", 3'd1, 1'b1, 3'd5, 16'h0, 16'h0, 16'h0003, 16'h001C);
        check("t6.pending_setwins", dut.pending_q, 8'h6C);

        bus.in_valid = 0; bus.wb_valid = 1;
        bus.wb_tgt = 3'd2; tick();
        bus.wb_tgt = 3'd3; tick();
        bus.wb_tgt = 3'd6; tick();
        bus.wb_valid = 0;
        check("t6.pending_retired", dut.pending_q, 8'h20);
        check("t6.idle", bus.out_valid, 1'b0);

        // ADD r0,r1,r2 alongside an ignored writeback to r0
        bus.in_valid = 1; bus.in_instr = 16'h0082; bus.in_pc = 16'h001E;
        bus.wb_valid = 1; bus.wb_tgt = 3'd0; bus.wb_data = 16'h7777;
        #1 check("t6.r0_in_ready", bus.in_ready, 1'b1);
        check("t6.r0_src1", bus.rf_src1, 3'd1);
        check("t6.r0_src2", bus.rf_src2, 3'd2);
        tick();
        bus.wb_valid = 0;
        check_out("t6.add_r0", 3'd0, 1'b0, 3'd0, 16'h1100, 16'h2200, 16'h0, 16'h001E);
        check("t6.pending_r0", dut.pending_q, 8'h20);

        // SW r2,r1,4: src1=rB, src2=rA, no target
        bus.in_instr = 16'h8884; bus.in_pc = 16'h0020;
        #1 check("sw.src1", bus.rf_src1, 3'd1);
        check("sw.src2", bus.rf_src2, 3'd2);
        tick();
        check_out("sw", 3'd4, 1'b0, 3'd0, 16'h1100, 16'h2200, 16'h0004, 16'h0020);

        // BEQ r5,r1,-2 stalls on pending r5; SW held by downstream stall
        bus.out_ready = 0; bus.in_instr = 16'hD4FE; bus.in_pc = 16'h0022;
        #1 check("beq.src1", bus.rf_src1, 3'd5);
        check("beq.src2", bus.rf_src2, 3'd1);
        check("beq.in_ready", bus.in_ready, 1'b0);
        tick();
        check("stall.pc", bus.out_pc, 16'h0020);

        // Reset mid-stall discards the held instruction
        #2 rst_n = 1'b0;
        #1 check("rst2.out_valid", bus.out_valid, 1'b0);
        check("rst2.pending", dut.pending_q, 8'h00);
        check("rst2.out_a", bus.out_a, 16'h0);
        check("rst2.out_pc", bus.out_pc, 16'h0);
        bus.in_valid = 0;
        #1 check("rst2.in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
